// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD stopwatch 00.00..99.99 in 0.01 s ticks, counting up or down from a preset.
// Optional lap freeze of the displayed value is built when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
    parameter int TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       mode,
    input  logic [7:0] preset,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [3:0] tenths,
    output logic [3:0] hundredths,
    output logic       running,
    output logic       done
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             r_start_q;
    logic             r_clear_q;
    logic             r_mode;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_running;
    logic             r_done;
    logic             w_running_next;
    logic             w_done_next;

    // Digit index 0 = hundredths .. 3 = tens.
    logic [3:0] r_dig      [0:3];
    logic [3:0] w_cnt_next [0:3];
    logic [3:0] w_load_dig [0:3];
    logic [3:0] w_up       [0:3];
    logic [3:0] w_dn       [0:3];
    logic [4:0] w_carry;
    logic [4:0] w_borrow;

    logic       w_start_pulse;
    logic       w_clear_pulse;
    logic [3:0] w_load_tens;
    logic [3:0] w_load_ones;
    logic       w_load_zero;
    logic       w_tick;
    logic       w_dn_is_zero;
    logic       w_terminal;
    logic       w_reload;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start_q <= 1'b0;
            r_clear_q <= 1'b0;
        end else begin
            r_start_q <= btn_start;
            r_clear_q <= btn_clear;
        end
    end

    assign w_start_pulse = btn_start & ~r_start_q;
    assign w_clear_pulse = btn_clear & ~r_clear_q;

    assign w_load_tens   = (preset[7:4] > 4'd9) ? 4'd9 : preset[7:4];
    assign w_load_ones   = (preset[3:0] > 4'd9) ? 4'd9 : preset[3:0];
    assign w_load_dig[3] = mode ? w_load_tens : 4'd0;
    assign w_load_dig[2] = mode ? w_load_ones : 4'd0;
    assign w_load_dig[1] = 4'd0;
    assign w_load_dig[0] = 4'd0;
    assign w_load_zero   = mode & (w_load_tens == 4'd0) & (w_load_ones == 4'd0);

    assign w_tick = (r_state == S_RUN) && (r_div == DIV_LAST);

    // Decimal ripple chains: a digit steps only when every lower digit wraps.
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign w_up[gi] = w_carry[gi]
                            ? ((r_dig[gi] == 4'd9) ? 4'd0 : r_dig[gi] + 4'd1)
                            : r_dig[gi];
            assign w_dn[gi] = w_borrow[gi]
                            ? ((r_dig[gi] == 4'd0) ? 4'd9 : r_dig[gi] - 4'd1)
                            : r_dig[gi];
            assign w_carry[gi+1]  = w_carry[gi]  & (r_dig[gi] == 4'd9);
            assign w_borrow[gi+1] = w_borrow[gi] & (r_dig[gi] == 4'd0);
        end
    endgenerate

    assign w_dn_is_zero = (w_dn[0] == 4'd0) && (w_dn[1] == 4'd0)
                       && (w_dn[2] == 4'd0) && (w_dn[3] == 4'd0);
    // w_borrow[4] guards a down count already sitting at 00.00 from wrapping to 99.99.
    assign w_terminal = w_tick & (r_mode ? (w_dn_is_zero | w_borrow[4]) : w_carry[4]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_clear_pulse && w_start_pulse) begin
                    w_state_next = w_load_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_clear_pulse)      w_state_next = S_IDLE;
                else if (w_terminal)    w_state_next = S_DONE;
                else if (w_start_pulse) w_state_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_clear_pulse)      w_state_next = S_IDLE;
                else if (w_start_pulse) w_state_next = S_RUN;
            end
            S_DONE: begin
                if (w_clear_pulse)      w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_running_next = (w_state_next == S_RUN);
        w_done_next    = (w_state_next == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_running <= w_running_next;
            r_done    <= w_done_next;
        end
    end

    // Mode and preset are only looked at while idle or on the edge returning to idle.
    assign w_reload = (r_state == S_IDLE) || (w_state_next == S_IDLE);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_cnt_next[i] = r_dig[i];
        end
        if (w_reload) begin
            for (int i = 0; i < 4; i++) begin
                w_cnt_next[i] = w_load_dig[i];
            end
        end else if (w_tick && !w_terminal) begin
            for (int i = 0; i < 4; i++) begin
                w_cnt_next[i] = r_mode ? w_dn[i] : w_up[i];
            end
        end else if (w_tick && r_mode) begin
            for (int i = 0; i < 4; i++) begin
                w_cnt_next[i] = 4'd0;
            end
        end
    end

    always_comb begin
        case (r_state)
            S_RUN:   w_div_next = w_tick ? '0 : r_div + DIV_W'(1);
            S_PAUSE: w_div_next = r_div;
            default: w_div_next = '0;
        endcase
        if ((w_state_next == S_IDLE) || (w_state_next == S_DONE)) begin
            w_div_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_mode <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_dig[i] <= 4'd0;
            end
        end else begin
            r_div <= w_div_next;
            if (w_reload) begin
                r_mode <= mode;
            end
            for (int i = 0; i < 4; i++) begin
                r_dig[i] <= w_cnt_next[i];
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       r_lap_q;
    logic       r_frozen;
    logic       w_frozen_next;
    logic       w_lap_pulse;
    logic [3:0] r_disp [0:3];

    assign w_lap_pulse = lap & ~r_lap_q;

    always_comb begin
        w_frozen_next = r_frozen;
        if ((w_state_next == S_IDLE) || (w_state_next == S_DONE)) begin
            w_frozen_next = 1'b0;
        end else if (w_lap_pulse) begin
            w_frozen_next = r_frozen ? 1'b0 : (r_state == S_RUN);
        end
    end

    // While frozen the display keeps the count it had on the lap edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lap_q  <= 1'b0;
            r_frozen <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_disp[i] <= 4'd0;
            end
        end else begin
            r_lap_q  <= lap;
            r_frozen <= w_frozen_next;
            for (int i = 0; i < 4; i++) begin
                if (!w_frozen_next) begin
                    r_disp[i] <= w_cnt_next[i];
                end
            end
        end
    end

    assign tens       = r_disp[3];
    assign ones       = r_disp[2];
    assign tenths     = r_disp[1];
    assign hundredths = r_disp[0];
`else
    assign tens       = r_dig[3];
    assign ones       = r_dig[2];
    assign tenths     = r_dig[1];
    assign hundredths = r_dig[0];
`endif

    assign running = r_running;
    assign done    = r_done;

endmodule
